// File: rtl/mole_arena.sv
// Whack-a-mole round controller: random mole patterns, shrinking hit window,
// hit/miss/clear/timeout pulses and a saturating level counter.
module mole_arena #(
  parameter int          N_HOLES   = 5,
  parameter int          TW        = 28,
  parameter int          GAP_TICKS = 2_000_000,
  parameter int          WIN_INIT  = 20_000_000,
  parameter int          WIN_MIN   = 5_000_000,
  parameter int          WIN_STEP  = 1_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_HOLES-1:0] button,
  output logic [N_HOLES-1:0] board_state,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               round_clear,
  output logic               round_timeout,
  output logic [3:0]         level
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    GAP    = 4'b0010,
    LOAD   = 4'b0100,
    ACTIVE = 4'b1000
  } state_t;

  localparam logic [TW-1:0] GAP_T      = TW'(GAP_TICKS);
  localparam logic [TW-1:0] WIN_INIT_T = TW'(WIN_INIT);
  localparam logic [TW-1:0] WIN_MIN_T  = TW'(WIN_MIN);
  localparam logic [TW-1:0] WIN_STEP_T = TW'(WIN_STEP);
  localparam logic [TW-1:0] ONE_T      = TW'(1);
  localparam logic [TW:0]   WIN_FLOOR  = (TW+1)'(WIN_MIN) + (TW+1)'(WIN_STEP);
  localparam logic [15:0]   LFSR_MASK  = 16'hD008;

  state_t             state;
  state_t             state_next;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_next;
  logic [TW-1:0]      window;
  logic [TW-1:0]      window_next;
  logic [TW-1:0]      window_dec;
  logic [15:0]        lfsr;
  logic [N_HOLES-1:0] board_next;
  logic [N_HOLES-1:0] board_after;
  logic [N_HOLES-1:0] load_pattern;
  logic [3:0]         level_next;
  logic               hit_next;
  logic               miss_next;
  logic               clear_next;
  logic               timeout_next;
  logic               timer_last;
  logic               is_clear;
  logic               is_timeout;
  logic               halted;

  // Free-running Galois LFSR; only a real reset reseeds it, enable never stalls it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign halted       = !rst_n || !enable;
  assign timer_last   = (timer == ONE_T);
  assign board_after  = board_state & ~button;
  assign load_pattern = (lfsr[N_HOLES-1:0] == '0) ? N_HOLES'(1) : lfsr[N_HOLES-1:0];

  // A clear wins over a timeout landing in the same cycle.
  assign is_clear   = (state == ACTIVE) && (board_after == '0);
  assign is_timeout = (state == ACTIVE) && !is_clear && timer_last;

  // Compare in TW+1 bits so the floor test cannot wrap.
  assign window_dec = ({1'b0, window} >= WIN_FLOOR) ? (window - WIN_STEP_T) : WIN_MIN_T;

  always_ff @(posedge clk) begin
    if (halted) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = GAP;
      GAP:     if (timer_last) state_next = LOAD;
      LOAD:    state_next = ACTIVE;
      ACTIVE:  if (is_clear || is_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_next   = timer;
    board_next   = board_state;
    window_next  = window;
    level_next   = level;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    clear_next   = 1'b0;
    timeout_next = 1'b0;
    unique case (state)
      IDLE: timer_next = GAP_T;
      GAP:  timer_next = timer - ONE_T;
      LOAD: begin
        board_next = load_pattern;
        timer_next = window;
      end
      ACTIVE: begin
        hit_next   = |(button & board_state);
        miss_next  = |(button & ~board_state);
        timer_next = timer - ONE_T;
        if (is_clear) begin
          clear_next  = 1'b1;
          board_next  = '0;
          window_next = window_dec;
          level_next  = (level == 4'd15) ? 4'd15 : level + 4'd1;
        end else if (is_timeout) begin
          timeout_next = 1'b1;
          board_next   = '0;
        end else begin
          board_next = board_after;
        end
      end
      default: timer_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (halted) begin
      timer         <= '0;
      window        <= WIN_INIT_T;
      board_state   <= '0;
      level         <= 4'd0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      round_clear   <= 1'b0;
      round_timeout <= 1'b0;
    end else begin
      timer         <= timer_next;
      window        <= window_next;
      board_state   <= board_next;
      level         <= level_next;
      hit_pulse     <= hit_next;
      miss_pulse    <= miss_next;
      round_clear   <= clear_next;
      round_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_mole_arena.sv
// Directed bench for mole_arena: a behavioural game model queues the expected
// outputs of every cycle, which are popped and compared after each clock edge.
module tb_mole_arena;

  localparam int          NH    = 5;
  localparam int          GAPT  = 4;
  localparam int          WINI  = 10;
  localparam int          WMIN  = 4;
  localparam int          WSTEP = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam int M_IDLE    = 0;
  localparam int M_CLEAR   = 1;
  localparam int M_MIXED   = 2;
  localparam int M_LASTHIT = 3;
  localparam int M_DROP    = 4;

  typedef struct packed {
    logic [NH-1:0] board;
    logic          hit;
    logic          miss;
    logic          clr;
    logic          to;
    logic [3:0]    level;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NH-1:0] button;
  logic [NH-1:0] board_state;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          round_clear;
  logic          round_timeout;
  logic [3:0]    level;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  // Game model: phase 0 idle, 1 gap, 2 load, 3 active; elapsed counts up within a phase.
  int            m_phase   = 0;
  int            m_elapsed = 0;
  int            m_win     = WINI;
  logic [NH-1:0] m_board   = '0;
  logic [3:0]    m_level   = 4'd0;
  logic [15:0]   m_lfsr    = SEED;

  always #5 clk = ~clk;

  mole_arena #(
    .N_HOLES(NH), .TW(16), .GAP_TICKS(GAPT), .WIN_INIT(WINI),
    .WIN_MIN(WMIN), .WIN_STEP(WSTEP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .button(button),
    .board_state(board_state), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .round_clear(round_clear), .round_timeout(round_timeout), .level(level)
  );

  function automatic logic [15:0] lfsrAdvance(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ ((16'd1 << 15) | (16'd1 << 14) | (16'd1 << 12) | (16'd1 << 3));
    return r;
  endfunction

  task automatic checkBits(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic e, input logic [NH-1:0] b);
    obs_t        o;
    logic [15:0] cur;
    o      = '0;
    cur    = m_lfsr;
    m_lfsr = r ? lfsrAdvance(cur) : SEED;
    if (!r || !e) begin
      m_phase = 0; m_elapsed = 0; m_board = '0; m_level = 4'd0; m_win = WINI;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_elapsed = 0; end
        1: if (m_elapsed == GAPT - 1) m_phase = 2; else m_elapsed++;
        2: begin
          m_board   = (cur[NH-1:0] == '0) ? NH'(1) : cur[NH-1:0];
          m_phase   = 3;
          m_elapsed = 0;
        end
        default: begin
          o.hit  = |(b & m_board);
          o.miss = |(b & ~m_board);
          if ((m_board & ~b) == '0) begin
            o.clr   = 1'b1;
            m_board = '0;
            m_win   = (m_win - WSTEP < WMIN) ? WMIN : m_win - WSTEP;
            if (m_level != 4'd15) m_level = m_level + 4'd1;
            m_phase = 0;
          end else if (m_elapsed == m_win - 1) begin
            o.to    = 1'b1;
            m_board = '0;
            m_phase = 0;
          end else begin
            m_board = m_board & ~b;
            m_elapsed++;
          end
        end
      endcase
    end
    o.board = m_board;
    o.level = m_level;
    exp_q.push_back(o);
  endtask

  task automatic checkOutput();
    obs_t e;
    if (exp_q.size() == 0) begin
      checkBits("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      checkBits("board_state",   16'(board_state),   16'(e.board));
      checkBits("hit_pulse",     16'(hit_pulse),     16'(e.hit));
      checkBits("miss_pulse",    16'(miss_pulse),    16'(e.miss));
      checkBits("round_clear",   16'(round_clear),   16'(e.clr));
      checkBits("round_timeout", 16'(round_timeout), 16'(e.to));
      checkBits("level",         16'(level),         16'(e.level));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [NH-1:0] b);
    rst_n  = r;
    enable = e;
    button = b;
    modelStep(r, e, b);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Plays one round with a press strategy chosen by mode; presses in gap/load are noise.
  task automatic runRound(input int mode, input int exp_latency);
    int            cyc = 0;
    int            up_at = -1;
    int            to_at = -1;
    logic          seen_active = 1'b0;
    logic          done = 1'b0;
    logic          en;
    logic          mixed;
    logic [NH-1:0] b;
    logic [NH-1:0] low_up;
    logic [NH-1:0] low_empty;
    while (!done && cyc < 200) begin
      en        = 1'b1;
      b         = '0;
      mixed     = 1'b0;
      low_up    = m_board & (~m_board + NH'(1));
      low_empty = ~m_board & (m_board + NH'(1));
      if (m_phase == 1 || m_phase == 2) begin
        b = NH'($urandom_range(1, (1 << NH) - 1));
      end else if (m_phase == 3) begin
        seen_active = 1'b1;
        case (mode)
          M_CLEAR:   b = low_up;
          M_MIXED: begin
            b     = (m_elapsed == 0) ? (low_up | low_empty) : low_up;
            mixed = (m_elapsed == 0) && (low_empty != '0);
          end
          M_LASTHIT: b = (m_elapsed == m_win - 1) ? m_board : '0;
          M_DROP:    en = (m_elapsed != 2);
          default:   b = '0;
        endcase
      end
      applyStimulus(1'b1, en, b);
      if (mixed) begin
        checkBits("mixed_hit",  16'(hit_pulse),  16'd1);
        checkBits("mixed_miss", 16'(miss_pulse), 16'd1);
      end
      if (board_state != '0 && up_at < 0) up_at = cyc;
      if (round_timeout) to_at = cyc;
      if (!en) begin
        checkBits("drop_board", 16'(board_state), 16'd0);
        checkBits("drop_level", 16'(level), 16'd0);
      end
      done = seen_active && (m_phase == 0);
      cyc++;
    end
    if (!done) checkBits("round_cycle_bound", 16'(cyc), 16'd0);
    if (exp_latency > 0) checkBits("timeout_latency", 16'(to_at - up_at), 16'(exp_latency));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    button = '0;
    repeat (3) applyStimulus(1'b0, 1'b0, '0);
    checkBits("reset_board", 16'(board_state), 16'd0);
    checkBits("reset_level", 16'(level), 16'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, NH'(5'b10101));

    runRound(M_IDLE, WINI);
    checkBits("level_after_timeout", 16'(level), 16'd0);
    runRound(M_CLEAR, 0);
    checkBits("level_after_clear1", 16'(level), 16'd1);
    runRound(M_MIXED, 0);
    checkBits("level_after_clear2", 16'(level), 16'd2);
    runRound(M_LASTHIT, 0);
    checkBits("level_after_lasthit", 16'(level), 16'd3);
    runRound(M_IDLE, WMIN);
    checkBits("level_after_floor_timeout", 16'(level), 16'd3);
    runRound(M_LASTHIT, 0);
    checkBits("level_after_floor_clear", 16'(level), 16'd4);
    runRound(M_DROP, 0);
    applyStimulus(1'b1, 1'b0, '0);
    runRound(M_IDLE, WINI);
    checkBits("level_after_reenable", 16'(level), 16'd0);
    repeat (3) applyStimulus(1'b1, 1'b1, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mole_arena.md
MOLE_ARENA -- requirements
Module: mole_arena

Interface
REQ-001 Parameter N_HOLES, default 5: number of holes/buttons, range 2..16.
REQ-002 Parameter TW, default 28: timer width in bits.
REQ-003 Parameter GAP_TICKS, default 2_000_000: blank-board dwell between rounds, in cycles.
REQ-004 Parameter WIN_INIT, default 20_000_000: active window of round 0, in cycles.
REQ-005 Parameter WIN_MIN, default 5_000_000: floor of the active window.
REQ-006 Parameter WIN_STEP, default 1_000_000: window reduction per cleared round.
REQ-007 Parameter LFSR_SEED, default 16'hACE1: nonzero seed of the internal 16-bit LFSR.
REQ-008 clk  input  1  system clock.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 enable  input  1  active high; game runs only while high.
REQ-011 button  input  N_HOLES  active-high one-cycle press pulses, one bit per hole.
REQ-012 board_state  output  N_HOLES  registered; bit high = mole up.
REQ-013 hit_pulse  output  1  registered one-cycle pulse, at least one mole hit.
REQ-014 miss_pulse  output  1  registered one-cycle pulse, press on an empty hole during ACTIVE.
REQ-015 round_clear  output  1  registered one-cycle pulse, board emptied before timeout.
REQ-016 round_timeout  output  1  registered one-cycle pulse, window expired with moles up.
REQ-017 level  output  4  count of cleared rounds, saturating at 15.

Function
REQ-018 One-hot FSM states: IDLE, GAP, LOAD, ACTIVE.
REQ-019 IDLE -> GAP unconditionally on the next cycle; timer loaded with GAP_TICKS on that transition.
REQ-020 GAP is held exactly GAP_TICKS cycles, then GAP -> LOAD; board_state stays zero throughout GAP.
REQ-021 LOAD lasts one cycle: board_state <= LFSR[N_HOLES-1:0], or 1 if that slice is zero; timer loaded with the current window; next state ACTIVE.
REQ-022 The LFSR advances every cycle after reset regardless of enable; it is a Galois LFSR with taps 16,15,13,4.
REQ-023 In ACTIVE: board_state <= board_state & ~button; hit_pulse asserts the next cycle iff (button & board_state) != 0.
REQ-024 In ACTIVE: miss_pulse asserts the next cycle iff (button & ~board_state) != 0; hit_pulse and miss_pulse may assert together.
REQ-025 Buttons in IDLE, GAP and LOAD are ignored: no pulses, no board change.
REQ-026 ACTIVE -> IDLE when the post-update board is zero (clear) or the window has run exactly its loaded length (timeout).
REQ-027 If the last mole is hit in the same cycle the window expires, the round counts as a clear, not a timeout.
REQ-028 On clear: round_clear pulses once; window <= max(window - WIN_STEP, WIN_MIN), computed without underflow; level increments, saturating at 15.
REQ-029 On timeout: round_timeout pulses once; board_state is cleared to zero; window and level are unchanged.
REQ-030 Timer arithmetic is TW bits; GAP_TICKS, WIN_INIT and WIN_MIN are each >= 1.

Reset
REQ-031 On rst_n low at a clk edge: state IDLE, board_state 0, all pulses 0, level 0, window WIN_INIT, timer 0, LFSR LFSR_SEED.
REQ-032 When enable is low at a clk edge, the block behaves as under reset, except that the LFSR keeps running; this applies mid-round as well, with no clear or timeout pulse emitted.
REQ-033 On the first cycle enable is high again, the FSM proceeds IDLE -> GAP.

Verification (N_HOLES=5, GAP_TICKS=4, WIN_INIT=10, WIN_MIN=4, WIN_STEP=3)
REQ-034 Hold enable high with no buttons -> GAP lasts 4 cycles; board nonzero from LOAD onward; round_timeout pulses 10 cycles after LOAD; board returns to 0; level stays 0.
REQ-035 Press exactly the up bits in ACTIVE -> hit_pulse per press, round_clear once, level 1, next window 7; then 4, then 4 (floor).
REQ-036 Press an empty hole and an up hole in the same cycle -> hit_pulse and miss_pulse both high for one cycle; only the up bit clears.
REQ-037 Press the last mole on the final window cycle -> round_clear only; level increments.
REQ-038 Drop enable mid-ACTIVE -> next cycle board 0, level 0, no pulses; re-raise -> GAP of 4 cycles, round 0 with window 10.
REQ-039 Presses during GAP and LOAD -> no hit_pulse or miss_pulse; board unaffected.
